// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for fifo_burst_reader: FSM state encoding and the
// helper that sizes the per-burst read counter.
package fifo_burst_reader_pkg;

  // Two-state FSM encoding, kept as plain constants for legacy tools.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Width needed to count 0..burst_len inclusive (the read counter must be
  // able to hold BURST_LEN itself to express "all reads issued").
  function automatic int burst_cnt_width(input int burst_len);
    return (burst_len < 2) ? 1 : $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_skid_buf.sv
// stream_skid_buf: 2-entry data+last FIFO that absorbs the one-cycle read
// latency of the upstream FIFO. The head entry drives the stream outputs.
module stream_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_last_o,
  output logic [1:0]            cnt_o
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic                  last_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q;

  // Storage write: the tail slot takes the incoming word on push.
  // NOTE: this storage is only two entries and the stream data must read 0
  // out of reset, so it is reset; larger RAM-style arrays should not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else if (push_i) begin
      data_q[wr_ptr_q] <= push_data_i;
      last_q[wr_ptr_q] <= push_last_i;
    end
  end

  // Pointer and occupancy update; push and pop together leave count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_data_o = data_q[rd_ptr_q];
  assign head_last_o = last_q[rd_ptr_q];
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains an upstream synchronous FIFO in fixed BURST_LEN
// bursts once almost_empty deasserts, and presents the words on a
// valid/ready stream with m_last on the final word of each burst.
// Optional statistics counters are enabled with FIFO_BURST_STATS_EN.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  burst_done
`ifdef FIFO_BURST_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  burst_count,
  output logic [CNT_WIDTH-1:0]  stall_count
`endif
);

  localparam int RD_W = burst_cnt_width(BURST_LEN);
  localparam logic [RD_W-1:0] RD_MAX  = RD_W'(BURST_LEN);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(BURST_LEN - 1);

  logic [0:0]            state_q, state_d;
  logic [RD_W-1:0]       rd_issued_q, rd_issued_d;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  pop;
  logic [2:0]            occupancy;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;

  assign busy       = (state_q == ST_BURST);
  assign m_valid    = (buf_cnt != 2'd0);
  assign m_data     = head_data;
  // Head last flag can be stale once the buffer drains, so gate it.
  assign m_last     = m_valid && head_last;
  assign pop        = m_valid && m_ready;
  assign burst_done = pop && m_last;

  // Credit rule: words held plus the word in flight, less the one leaving
  // this cycle, must leave room for the read issued now.
  assign occupancy  = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = busy && !fifo_empty && (rd_issued_q < RD_MAX) &&
                      (occupancy < 3'd2);

  // Next-state and read-count logic.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_d     = state_q;
    rd_issued_d = rd_issued_q;
    if (state_q == ST_IDLE) begin
      rd_issued_d = '0;
      if (!fifo_almost_empty) state_d = ST_BURST;
    end else begin
      if (fifo_rd_en) rd_issued_d = rd_issued_q + RD_W'(1);
      if (burst_done) state_d = ST_IDLE;
    end
  end

  // FSM, read counter and in-flight tracking; the last flag is decided at
  // issue time from the read index, so reordering cannot move it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      rd_issued_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_issued_q     <= rd_issued_d;
      inflight_q      <= fifo_rd_en;
      inflight_last_q <= fifo_rd_en && (rd_issued_q == RD_LAST);
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_dout),
    .push_last_i (inflight_last_q),
    .pop_i       (pop),
    .head_data_o (head_data),
    .head_last_o (head_last),
    .cnt_o       (buf_cnt)
  );

`ifdef FIFO_BURST_STATS_EN
  logic                 stall_cond;
  logic [CNT_WIDTH-1:0] burst_count_q;
  logic [CNT_WIDTH-1:0] stall_count_q;

  assign stall_cond = busy && fifo_empty && (rd_issued_q < RD_MAX);

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (burst_done && (burst_count_q != '1)) burst_count_q <= burst_count_q + CNT_WIDTH'(1);
      if (stall_cond && (stall_count_q != '1)) stall_count_q <= stall_count_q + CNT_WIDTH'(1);
    end
  end

  assign burst_count = burst_count_q;
  assign stall_count = stall_count_q;
`else
  // CNT_WIDTH only sizes the statistics counters; tie it off here.
  logic unused_cnt_width;
  assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: behavioural FIFO model (registered read,
// almost_empty when <=2 words), directed stimulus, scoreboard queue checked
// by an independent stream monitor. Define FIFO_BURST_STATS_EN to also
// exercise the statistics counters.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty;
  logic          fifo_almost_empty;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b1;
  logic          busy;
  logic          burst_done;
`ifdef FIFO_BURST_STATS_EN
  logic [CW-1:0] burst_count;
  logic [CW-1:0] stall_count;
`endif

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_rd_en        (fifo_rd_en),
    .fifo_dout         (fifo_dout),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .m_valid           (m_valid),
    .m_data            (m_data),
    .m_last            (m_last),
    .m_ready           (m_ready),
    .busy              (busy),
    .burst_done        (burst_done)
`ifdef FIFO_BURST_STATS_EN
    ,
    .burst_count       (burst_count),
    .stall_count       (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model (depth 16, registered read) ----------------
  logic [DW-1:0] fq[$];
  int            fifo_cnt = 0;
  int            rd_cnt   = 0;
  logic          wr_en    = 1'b0;
  logic [DW-1:0] wr_data  = '0;
  logic          flush    = 1'b0;

  assign fifo_empty        = (fifo_cnt == 0);
  assign fifo_almost_empty = (fifo_cnt <= 2);

  always @(posedge clk) begin
    if (flush) begin
      fq.delete();
    end else begin
      if (fifo_rd_en && fq.size() > 0) begin
        fifo_dout <= fq.pop_front();
        rd_cnt++;
      end
      if (wr_en && fq.size() < 16) fq.push_back(wr_data);
    end
    fifo_cnt <= fq.size();
  end

  // ---------------- Scoreboard monitor ----------------
  beat_t         exp_q[$];
  int            done_cnt = 0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready)
        check("stall_hold", {22'd0, m_valid, m_last, m_data}, {22'd0, 1'b1, prev_last, prev_data});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", {24'd0, m_data}, {24'd0, e.data});
          check("beat_last", {31'd0, m_last}, {31'd0, e.last});
          check("burst_done", {31'd0, burst_done}, {31'd0, e.last});
        end
      end else if (burst_done) begin
        check("spurious_done", 32'd1, 32'd0);
      end
      if (fifo_rd_en && fifo_empty) check("rd_on_empty", 32'd1, 32'd0);
      if (burst_done) done_cnt++;
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic push_expected(input int first, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = DW'(first + i);
      b.last = ((i + 1) % BL) == 0;
      exp_q.push_back(b);
    end
  endtask

  task automatic write_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = DW'(first + i);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst   = 1'b0;
    flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},  {31'd0, fifo_rd_en}, 32'd0);
    check({tag, "_valid"},  {31'd0, m_valid},    32'd0);
    check({tag, "_data"},   {24'd0, m_data},     32'd0);
    check({tag, "_last"},   {31'd0, m_last},     32'd0);
    check({tag, "_busy"},   {31'd0, busy},       32'd0);
    check({tag, "_done"},   {31'd0, burst_done}, 32'd0);
  endtask

  task automatic wait_done(input int n, input int budget);
    int base;
    base = done_cnt;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (done_cnt >= base + n) break;
    end
    #1;
    check("done_count", done_cnt - base, n);
  endtask

  // ---------------- Directed tests ----------------
  initial begin
    int rd_base;
    int wait_c;

    // Reset state
    #2;
    check_reset_outputs("reset");
    do_reset();

    // Test 1: 14 words, m_ready=1 -> three bursts, 13/14 remain
    m_ready = 1'b1;
    push_expected(1, 12);
    fork
      write_words(1, 14);
    join_none
    wait_done(3, 300);
    repeat (6) @(posedge clk);
    #1;
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    check("t1_idle_valid", {31'd0, m_valid}, 32'd0);
    check("t1_fifo_left", fifo_cnt, 2);
    check("t1_sb_empty", exp_q.size(), 0);

    // Test 2: same fill, m_ready toggles every cycle
    do_reset();
    push_expected(1, 12);
    fork
      write_words(1, 14);
    join_none
    begin
      int base2;
      base2 = done_cnt;
      for (int c = 0; c < 400 && done_cnt < base2 + 3; c++) begin
        @(posedge clk); #1;
        m_ready = ~m_ready;
      end
      check("t2_done_count", done_cnt - base2, 3);
    end
    m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t2_fifo_left", fifo_cnt, 2);
    check("t2_sb_empty", exp_q.size(), 0);

    // Test 3: 3 words, 20-cycle gap, then the 4th
    do_reset();
    push_expected(1, 4);
    write_words(1, 3);
    repeat (20) @(posedge clk);
    #1;
    check("t3_stall_busy", {31'd0, busy}, 32'd1);
    check("t3_stall_valid", {31'd0, m_valid}, 32'd0);
`ifdef FIFO_BURST_STATS_EN
    check("t3_stall_count_nz", {31'd0, stall_count != '0}, 32'd1);
`endif
    write_words(4, 1);
    wait_done(1, 50);
    check("t3_sb_empty", exp_q.size(), 0);

    // Test 4: m_ready low at burst start -> at most two reads outstanding
    do_reset();
    m_ready = 1'b0;
    rd_base = rd_cnt;
    push_expected(1, 4);
    write_words(1, 4);
    repeat (10) @(posedge clk);
    #1;
    check("t4_reads_held", rd_cnt - rd_base, 2);
    check("t4_valid_held", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b1;
    wait_done(1, 50);
    check("t4_sb_empty", exp_q.size(), 0);

    // Test 5: reset during the 2nd beat
    do_reset();
    m_ready = 1'b0;
    rd_base = rd_cnt;
    push_expected(1, 1);
    exp_q[0].last = 1'b0;
    write_words(1, 8);
    wait_c = 0;
    while (!m_valid && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    check("t5_first_valid", {31'd0, m_valid}, 32'd1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("t5_reads_before_rst", rd_cnt - rd_base, 3);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("t5_midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("t5_sb_empty_pre", exp_q.size(), 0);
    push_expected(4, 4);
    m_ready = 1'b1;
    wait_done(1, 60);
    repeat (4) @(posedge clk);
    #1;
    check("t5_fifo_left", fifo_cnt, 1);
    check("t5_idle", {31'd0, busy}, 32'd0);
    check("t5_sb_empty", exp_q.size(), 0);

`ifdef FIFO_BURST_STATS_EN
    // Test 6: five bursts counted, counters cleared by reset
    do_reset();
    check("t6_bc_reset", {16'd0, burst_count}, 32'd0);
    check("t6_sc_reset", {16'd0, stall_count}, 32'd0);
    m_ready = 1'b1;
    push_expected(1, 20);
    fork
      write_words(1, 22);
    join_none
    wait_done(5, 400);
    repeat (4) @(posedge clk);
    #1;
    check("t6_burst_count", {16'd0, burst_count}, 32'd5);
    do_reset();
    check("t6_bc_cleared", {16'd0, burst_count}, 32'd0);
    check("t6_sc_cleared", {16'd0, stall_count}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
